// File: rtl/sram_req_arbiter.sv
// Fixed-priority (data over inst) arbiter sharing one SRAM-like port between
// the fetch and MEM-stage masters, with an in-order ID FIFO steering each response.

module sram_req_arbiter_chk #(
    parameter int MAX_OUTS = 2,
    parameter int CNT_W    = $clog2(MAX_OUTS + 1)
) (
    input logic             clk,
    input logic             resetn,
    input logic [CNT_W-1:0] count_i,
    input logic             bus_req_i,
    input logic             inst_addr_ok_i,
    input logic             data_addr_ok_i,
    input logic             inst_data_ok_i,
    input logic             data_data_ok_i
);

    a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
        count_i <= CNT_W'(MAX_OUTS));

    a_one_addr_ok: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_addr_ok_i && data_addr_ok_i));

    a_one_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_data_ok_i && data_data_ok_i));

    a_ack_needs_req: assert property (@(posedge clk) disable iff (!resetn)
        (inst_addr_ok_i || data_addr_ok_i) |-> bus_req_i);

    a_no_req_when_full: assert property (@(posedge clk) disable iff (!resetn)
        (count_i == CNT_W'(MAX_OUTS)) |-> !bus_req_i);

endmodule

module sram_req_arbiter #(
    parameter int MAX_OUTS = 2,
    parameter int CNT_W    = $clog2(MAX_OUTS + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTS - 1);
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTS-1:0] id_q, id_d;

    logic owner_s;
    logic owner_req_s;
    logic full_s;
    logic push_s;
    logic pop_s;
    logic head_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Owner selection: live priority in ARB, frozen owner while a request stalls
    always_comb begin
        owner_s     = owner_q;
        owner_req_s = 1'b0;
        if (state_q == ST_HOLD) begin
            owner_s = owner_q;
        end else begin
            owner_s = data_req ? OWN_DATA : OWN_INST;
        end
        case (owner_s)
            OWN_DATA: owner_req_s = data_req;
            default:  owner_req_s = inst_req;
        endcase
    end

    // Request qualification; reset forces the port idle without waiting for a clock
    always_comb begin
        full_s  = (count_q == CNT_MAX);
        bus_req = owner_req_s & ~full_s & resetn;
        push_s  = bus_req & bus_addr_ok;
        pop_s   = bus_data_ok & (count_q != {CNT_W{1'b0}});
        head_s  = id_q[rd_ptr_q];
    end

    // Forward the owner's request fields; fetches are always plain reads
    always_comb begin
        bus_wr    = 1'b0;
        bus_wstrb = 4'b0000;
        bus_addr  = 32'h0000_0000;
        bus_wdata = 32'h0000_0000;
        case (owner_s)
            OWN_DATA: begin
                bus_wr    = data_wr;
                bus_wstrb = data_wstrb;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
            end
            default: begin
                bus_wr    = 1'b0;
                bus_wstrb = 4'b0000;
                bus_addr  = inst_addr;
                bus_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Acknowledge steering: address acks follow the owner, responses follow the FIFO head
    always_comb begin
        inst_addr_ok = push_s & (owner_s == OWN_INST);
        data_addr_ok = push_s & (owner_s == OWN_DATA);
        inst_data_ok = pop_s & (head_s == OWN_INST);
        data_data_ok = pop_s & (head_s == OWN_DATA);
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
    end

    // Grant FSM next state: leave HOLD on acceptance or when the owner withdraws
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_ARB: begin
                if (bus_req && !bus_addr_ok) begin
                    state_d = ST_HOLD;
                    owner_d = owner_s;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_HOLD: begin
                if (push_s) begin
                    state_d = ST_ARB;
                end else if (!owner_req_s) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ARB;
                owner_d = OWN_INST;
            end
        endcase
    end

    // Outstanding-ID FIFO bookkeeping; push and pop may happen in the same cycle
    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            id_d[wr_ptr_q] = owner_s;
            wr_ptr_d       = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State and FIFO registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_ARB;
            owner_q  <= OWN_INST;
            count_q  <= {CNT_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            id_q     <= {MAX_OUTS{1'b0}};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            id_q     <= id_d;
        end
    end

    sram_req_arbiter_chk #(
        .MAX_OUTS (MAX_OUTS),
        .CNT_W    (CNT_W)
    ) u_chk (
        .clk            (clk),
        .resetn         (resetn),
        .count_i        (count_q),
        .bus_req_i      (bus_req),
        .inst_addr_ok_i (inst_addr_ok),
        .data_addr_ok_i (data_addr_ok),
        .inst_data_ok_i (inst_data_ok),
        .data_data_ok_i (data_data_ok)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based transaction model.

module tb_sram_req_arbiter;

    localparam int MAX_OUTS = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_OUTS(MAX_OUTS)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: queue of masters whose requests were accepted but not answered,
    // plus which master (if any) is stuck waiting on an unaccepted address.
    bit pend[$];
    bit stalled = 1'b0;
    bit stalled_master = 1'b0;
    bit m_master, m_wants, m_breq, m_accept, m_resp;

    always @(negedge clk) begin : compare
        bit master, wants, full, breq, accept, resp, head;
        #1;
        master = stalled ? stalled_master : data_req;
        wants  = master ? data_req : inst_req;
        full   = (pend.size() >= MAX_OUTS);
        breq   = resetn && wants && !full;
        accept = breq && bus_addr_ok;
        resp   = resetn && bus_data_ok && (pend.size() > 0);
        head   = resp ? pend[0] : 1'b0;
        m_master = master;
        m_wants  = wants;
        m_breq   = breq;
        m_accept = accept;
        m_resp   = resp;

        check("m_bus_req", bus_req, breq);
        check("m_inst_addr_ok", inst_addr_ok, accept && !master);
        check("m_data_addr_ok", data_addr_ok, accept && master);
        check("m_inst_data_ok", inst_data_ok, resp && !head);
        check("m_data_data_ok", data_data_ok, resp && head);
        if (breq) begin
            check("m_bus_addr", bus_addr, master ? data_addr : inst_addr);
            check("m_bus_wr", bus_wr, master ? data_wr : 1'b0);
            check("m_bus_wstrb", bus_wstrb, master ? data_wstrb : 4'b0000);
            check("m_bus_wdata", bus_wdata, master ? data_wdata : 32'h0000_0000);
        end
        if (resp && !head) check("m_inst_rdata", inst_rdata, bus_rdata);
        if (resp && head)  check("m_data_rdata", data_rdata, bus_rdata);
    end

    always @(posedge clk or negedge resetn) begin : model_update
        if (!resetn) begin
            pend.delete();
            stalled = 1'b0;
        end else begin
            if (m_resp) void'(pend.pop_front());
            if (m_accept) pend.push_back(m_master);
            if (m_breq && !bus_addr_ok) begin
                stalled        = 1'b1;
                stalled_master = m_master;
            end else begin
                stalled = stalled && m_wants && !m_accept;
            end
        end
    end

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_addr   = 32'h0000_0000;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'b0000;
        data_addr   = 32'h0000_0000;
        data_wdata  = 32'h0000_0000;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0000_0000;
    endtask

    // Next falling edge, drive one cycle of inputs, then settle for literal checks
    task automatic apply(input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic dwr, input logic [3:0] dstrb,
                         input logic [31:0] daddr, input logic [31:0] dwdata,
                         input logic aok, input logic dok, input logic [31:0] rdata);
        @(negedge clk);
        inst_req    = ireq;
        inst_addr   = iaddr;
        data_req    = dreq;
        data_wr     = dwr;
        data_wstrb  = dstrb;
        data_addr   = daddr;
        data_wdata  = dwdata;
        bus_addr_ok = aok;
        bus_data_ok = dok;
        bus_rdata   = rdata;
        #2;
    endtask

    initial begin
        int p_req, p_aok, p_dok;
        resetn = 1'b0;
        idle_inputs();

        // Reset: requests present but port stays idle
        apply(1'b1, 32'h1C00_0010, 1'b1, 1'b0, 4'h0, 32'h1C00_0020, 32'h0, 1'b1, 1'b1, 32'h0);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        check("rst_data_addr_ok", data_addr_ok, 1'b0);
        check("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        idle_inputs();

        // Both request together: data first, inst next, responses in the same order
        apply(1'b1, 32'h1C00_0010, 1'b1, 1'b0, 4'h0, 32'h1C00_0020, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t1_data_grant", data_addr_ok, 1'b1);
        check("t1_inst_wait", inst_addr_ok, 1'b0);
        check("t1_addr_data", bus_addr, 32'h1C00_0020);
        apply(1'b1, 32'h1C00_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t1_inst_grant", inst_addr_ok, 1'b1);
        check("t1_addr_inst", bus_addr, 32'h1C00_0010);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0001);
        check("t1_resp1_data", {inst_data_ok, data_data_ok}, 2'b01);
        check("t1_resp1_rdata", data_rdata, 32'hAAAA_0001);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBBBB_0002);
        check("t1_resp2_inst", {inst_data_ok, data_data_ok}, 2'b10);
        check("t1_resp2_rdata", inst_rdata, 32'hBBBB_0002);

        // Stalled inst request keeps the grant against a later data request
        apply(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t2_req", bus_req, 1'b1);
        check("t2_addr0", bus_addr, 32'h1C00_0000);
        apply(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 4'h0, 32'h1C00_0200, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t2_addr1", bus_addr, 32'h1C00_0000);
        apply(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 4'h0, 32'h1C00_0200, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t2_addr2", bus_addr, 32'h1C00_0000);
        apply(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 4'h0, 32'h1C00_0200, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t2_inst_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
        check("t2_addr3", bus_addr, 32'h1C00_0000);
        apply(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1C00_0200, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t2_data_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
        check("t2_addr4", bus_addr, 32'h1C00_0200);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1111_0000);
        check("t2_resp_inst", {inst_data_ok, data_data_ok}, 2'b10);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2222_0000);
        check("t2_resp_data", {inst_data_ok, data_data_ok}, 2'b01);

        // Outstanding limit: third request blocked, a response frees a slot next cycle
        apply(1'b1, 32'h1C00_0300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t3_acc1", inst_addr_ok, 1'b1);
        apply(1'b1, 32'h1C00_0304, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t3_acc2", inst_addr_ok, 1'b1);
        apply(1'b1, 32'h1C00_0308, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t3_full_req", bus_req, 1'b0);
        check("t3_full_ok", inst_addr_ok, 1'b0);
        apply(1'b1, 32'h1C00_0308, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h3333_0000);
        check("t3_nobypass_req", bus_req, 1'b0);
        check("t3_nobypass_ok", inst_addr_ok, 1'b0);
        check("t3_pop", inst_data_ok, 1'b1);
        apply(1'b1, 32'h1C00_0308, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t3_after_pop", inst_addr_ok, 1'b1);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4444_0000);
        check("t3_drain", inst_data_ok, 1'b1);

        // One inst transaction outstanding, then a stray response on an empty FIFO
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        check("t4_inst_ok", {inst_data_ok, data_data_ok}, 2'b10);
        check("t4_rdata", inst_rdata, 32'h1234_5678);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_0000);
        check("t4_stray", {inst_data_ok, data_data_ok}, 2'b00);

        // Write forwarding
        apply(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h1C00_0100, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        check("t5_wr", bus_wr, 1'b1);
        check("t5_wstrb", bus_wstrb, 4'b0011);
        check("t5_addr", bus_addr, 32'h1C00_0100);
        check("t5_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("t5_addr_ok", data_addr_ok, 1'b1);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        check("t5_wr_ack", {inst_data_ok, data_data_ok}, 2'b01);

        // Asynchronous reset while a data request stalls with one transaction outstanding
        apply(1'b1, 32'h1C00_0400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t6_acc", inst_addr_ok, 1'b1);
        apply(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1C00_0500, 32'h0, 1'b0, 1'b0, 32'h0);
        apply(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1C00_0500, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t6_hold_req", bus_req, 1'b1);
        #1;
        resetn      = 1'b0;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        #1;
        check("t6_rst_req", bus_req, 1'b0);
        check("t6_rst_addr_ok", data_addr_ok, 1'b0);
        check("t6_rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        idle_inputs();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h6666_0000;
        #2;
        check("t6_stray", {inst_data_ok, data_data_ok}, 2'b00);
        apply(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1C00_0600, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t6_post_acc", data_addr_ok, 1'b1);
        check("t6_post_addr", bus_addr, 32'h1C00_0600);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7777_0000);
        check("t6_post_resp", {inst_data_ok, data_data_ok}, 2'b01);

        // Randomized traffic with varying request/accept/response rates
        p_req = 50;
        p_aok = 50;
        p_dok = 50;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ((cyc % 250) == 0) begin
                p_req = 20 + $urandom_range(70);
                p_aok = 10 + $urandom_range(85);
                p_dok = 10 + $urandom_range(85);
            end
            @(negedge clk);
            inst_req    = ($urandom_range(99) < p_req);
            data_req    = ($urandom_range(99) < p_req);
            inst_addr   = {$urandom_range(3), 28'h0000_000} | ($urandom & 32'h0000_FFFC);
            data_addr   = $urandom;
            data_wr     = $urandom_range(1);
            data_wstrb  = 4'($urandom_range(15));
            data_wdata  = $urandom;
            bus_addr_ok = ($urandom_range(99) < p_aok);
            bus_data_ok = ($urandom_range(99) < p_dok);
            bus_rdata   = $urandom;
        end

        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
